uart_tx: RTL and testbench

//  - UART serial transmitter; the transmit end of the UART link whose divisor comes from baud_gen.
//  - Accepts a parallel byte via a valid/ready handshake and shifts out a frame on txd:

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_if.sv | 18 +
 rtl/uart_tick_gen.sv | 31 +++
 rtl/uart_tx.sv | 153 +++++++++++++++
 tb/tb_uart_tx.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter and its tick generator.
// Optional parity support is selected by the UART_TX_PARITY_EN macro.
package uart_pkg;

   localparam int   OVERSAMPLE_DEF = 16;
   localparam int   DIV_W_DEF      = 16;
   localparam logic TXD_IDLE       = 1'b1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } uart_state_e;

   // Narrower bytes are zero-extended by the caller, which leaves the XOR unchanged.
   function automatic logic parity_of(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and uart_tx; parity_odd exists only
// when UART_TX_PARITY_EN is defined.
interface uart_tx_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
`ifdef UART_TX_PARITY_EN
   logic                 parity_odd;

   modport master (output tx_data, output tx_valid, output parity_odd, input tx_ready);
   modport slave  (input tx_data, input tx_valid, input parity_odd, output tx_ready);
`else
   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
`endif
endinterface

// File: rtl/uart_tick_gen.sv
// Reloadable divisor counter: one tick every div+1 clocks while clr is low.
// Shared between the UART transmitter and receiver.
module uart_tick_gen #(
   parameter int DIV_W = 16
) (
   input  logic             ipclk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_r;

   // Tick fires on the clock where the counter has reached the divisor.
   always_comb begin
      tick = (cnt_r == div);
   end

   // Count up to div, then reload to zero; clr holds the phase at zero.
   always_ff @(posedge ipclk) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (clr || tick) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity
// (UART_TX_PARITY_EN), one stop bit, at OVERSAMPLE ticks per bit.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DIV_W      = DIV_W_DEF
) (
   input  logic             ipclk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] divisor,
   uart_tx_if.slave         tx,
   output logic             txd,
   output logic             busy
);

   localparam int SUB_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   logic [2:0]           state_r;
   logic [DATA_BITS-1:0] shift_r;
   logic [DIV_W-1:0]     div_q_r;
   logic [SUB_W-1:0]     sub_r;
   logic [BIT_W-1:0]     bit_r;
   logic                 txd_r;
   logic                 busy_r;
   logic                 ready_r;
`ifdef UART_TX_PARITY_EN
   logic                 par_r;
`endif

   logic tick_s;
   logic clr_s;
   logic accept_s;
   logic bit_done_s;

   // The tick phase is pinned at zero while idle, so every frame starts a fresh bit time.
   always_comb begin
      accept_s   = tx.tx_valid & ready_r;
      clr_s      = (state_r == ST_IDLE);
      bit_done_s = tick_s & (sub_r == SUB_LAST) & ~clr_s;
   end

   uart_tick_gen #(
      .DIV_W (DIV_W)
   ) u_tick_gen (
      .ipclk (ipclk),
      .rst_n (rst_n),
      .clr   (clr_s),
      .div   (div_q_r),
      .tick  (tick_s)
   );

   // Sub-tick counter: OVERSAMPLE ticks make one bit time.
   always_ff @(posedge ipclk) begin
      if (!rst_n) begin
         sub_r <= '0;
      end else if (clr_s) begin
         sub_r <= '0;
      end else if (tick_s) begin
         sub_r <= (sub_r == SUB_LAST) ? '0 : sub_r + SUB_W'(1);
      end else begin
         sub_r <= sub_r;
      end
   end

   // Frame FSM with registered line, busy and ready outputs.
   always_ff @(posedge ipclk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         shift_r <= '0;
         div_q_r <= '0;
         bit_r   <= '0;
         txd_r   <= TXD_IDLE;
         busy_r  <= 1'b0;
         ready_r <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  shift_r <= tx.tx_data;
                  div_q_r <= divisor;
                  bit_r   <= '0;
                  state_r <= ST_START;
                  txd_r   <= 1'b0;
                  busy_r  <= 1'b1;
                  ready_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  par_r   <= parity_of(8'(tx.tx_data), tx.parity_odd);
`endif
               end
            end
            ST_START: begin
               if (bit_done_s) begin
                  state_r <= ST_DATA;
                  txd_r   <= shift_r[0];
                  bit_r   <= '0;
               end
            end
            ST_DATA: begin
               if (bit_done_s) begin
                  if (bit_r == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                     state_r <= ST_PARITY;
                     txd_r   <= par_r;
`else
                     state_r <= ST_STOP;
                     txd_r   <= TXD_IDLE;
`endif
                  end else begin
                     shift_r <= shift_r >> 1;
                     txd_r   <= shift_r[1];
                     bit_r   <= bit_r + BIT_W'(1);
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_done_s) begin
                  state_r <= ST_STOP;
                  txd_r   <= TXD_IDLE;
               end
            end
`endif
            ST_STOP: begin
               if (bit_done_s) begin
                  state_r <= ST_IDLE;
                  txd_r   <= TXD_IDLE;
                  busy_r  <= 1'b0;
                  ready_r <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               txd_r   <= TXD_IDLE;
               busy_r  <= 1'b0;
               ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign txd         = txd_r;
   assign busy        = busy_r;
   assign tx.tx_ready = ready_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx; build with UART_TX_PARITY_EN defined to
// exercise the parity frame as well.
module tb_uart_tx;

   localparam int DATA_BITS  = 8;
   localparam int OVERSAMPLE = 16;
`ifdef UART_TX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   logic        ipclk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] divisor = 16'd0;
   logic        txd;
   logic        busy;

   int tests_run    = 0;
   int tests_failed = 0;

   uart_tx_if #(.DATA_BITS(DATA_BITS)) tx_if ();

   uart_tx #(
      .DATA_BITS  (DATA_BITS),
      .OVERSAMPLE (OVERSAMPLE),
      .DIV_W      (16)
   ) dut (
      .ipclk   (ipclk),
      .rst_n   (rst_n),
      .divisor (divisor),
      .tx      (tx_if.slave),
      .txd     (txd),
      .busy    (busy)
   );

   always #5 ipclk = ~ipclk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Reference frame: bit i of the result is the line level during bit time i.
   function automatic logic [15:0] frame_bits(input logic [7:0] data, input logic par_odd);
      logic [15:0] f;
      logic        p;
      f    = 16'hFFFF;
      f[0] = 1'b0;
      for (int i = 0; i < DATA_BITS; i++) f[1+i] = data[i];
      p = 1'(($countones(data) + int'(par_odd)) % 2);
      f[1+DATA_BITS] = (PAR_BITS == 1) ? p : 1'b1;
      return f;
   endfunction

   task automatic present(input logic [7:0] data, input int div);
      tx_if.tx_data  = data;
      tx_if.tx_valid = 1'b1;
      divisor        = 16'(div);
   endtask

   task automatic check_idle(input string tag);
      tests_run++;
      if ({txd, busy, tx_if.tx_ready} !== 3'b101) begin
         tests_failed++;
         $display("FAIL %s: {txd,busy,tx_ready}=%b expected 101", tag, {txd, busy, tx_if.tx_ready});
      end
   endtask

   // Follows one frame from its accept edge; the DUT must be idle with tx_valid set on entry.
   task automatic expect_frame(input logic [7:0] data, input int div, input logic par_odd,
                               input bit keep_valid, input logic [7:0] next_data,
                               input int next_div, input string tag);
      logic [15:0] exp;
      logic        obs;
      int          bt, nbits, busy_cnt, ready_cnt;
      exp       = frame_bits(data, par_odd);
      bt        = OVERSAMPLE * (div + 1);
      nbits     = DATA_BITS + 2 + PAR_BITS;
      busy_cnt  = 0;
      ready_cnt = 0;
      obs       = 1'b0;
      @(posedge ipclk); #1;
      if (keep_valid) tx_if.tx_data = next_data;
      else            tx_if.tx_valid = 1'b0;
      divisor = 16'(next_div);
      for (int i = 0; i < nbits; i++) begin
         for (int j = 0; j < bt; j++) begin
            if (i != 0 || j != 0) begin
               @(posedge ipclk); #1;
            end
            if (j == 0)          obs = txd;
            else if (txd !== obs) obs = 1'bx;
            if (busy === 1'b1)           busy_cnt++;
            if (tx_if.tx_ready !== 1'b0) ready_cnt++;
         end
         tests_run++;
         if (obs !== exp[i]) begin
            tests_failed++;
            $display("FAIL %s bit%0d: txd=%b over the bit, expected %b", tag, i, obs, exp[i]);
         end
      end
      tests_run++;
      if (busy_cnt != nbits * bt) begin
         tests_failed++;
         $display("FAIL %s busy_len: %0d clocks, expected %0d", tag, busy_cnt, nbits * bt);
      end
      tests_run++;
      if (ready_cnt != 0) begin
         tests_failed++;
         $display("FAIL %s ready_in_frame: high %0d clocks, expected 0", tag, ready_cnt);
      end
      @(posedge ipclk); #1;
      check_idle({tag, "_end"});
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = 8'h55;
      for (int k = 0; k < 3; k++) begin
         @(posedge ipclk); #1;
         check_idle("reset_hold");
      end
      tx_if.tx_valid = 1'b0;
      rst_n          = 1'b1;
      @(posedge ipclk); #1;
      check_idle("reset_release");
   endtask

   task automatic test_a5();
      present(8'hA5, 3);
      expect_frame(8'hA5, 3, 1'b0, 1'b0, 8'h00, 3, "a5_div3");
   endtask

   task automatic test_parity();
`ifdef UART_TX_PARITY_EN
      tx_if.parity_odd = 1'b0;
      present(8'hA5, 3);
      expect_frame(8'hA5, 3, 1'b0, 1'b0, 8'h00, 3, "par_even");
      tx_if.parity_odd = 1'b1;
      present(8'hA5, 3);
      expect_frame(8'hA5, 3, 1'b1, 1'b0, 8'h00, 3, "par_odd");
      tx_if.parity_odd = 1'b0;
`endif
   endtask

   task automatic test_back_to_back();
      present(8'h00, 0);
      expect_frame(8'h00, 0, 1'b0, 1'b1, 8'hFF, 0, "b2b_first");
      expect_frame(8'hFF, 0, 1'b0, 1'b0, 8'h00, 0, "b2b_second");
   endtask

   task automatic test_div_change();
      logic [7:0] d1, d2;
      d1 = 8'($urandom);
      d2 = 8'($urandom);
      present(d1, 3);
      expect_frame(d1, 3, 1'b0, 1'b0, 8'h00, 7, "divchg_old");
      present(d2, 7);
      expect_frame(d2, 7, 1'b0, 1'b0, 8'h00, 7, "divchg_new");
   endtask

   task automatic test_midframe_reset();
      logic [7:0]  d;
      logic [15:0] exp;
      d   = 8'($urandom);
      exp = frame_bits(d, 1'b0);
      present(d, 3);
      @(posedge ipclk); #1;
      tx_if.tx_valid = 1'b0;
      repeat (4 * 64 + 10) begin
         @(posedge ipclk); #1;
      end
      tests_run++;
      if (txd !== exp[4]) begin
         tests_failed++;
         $display("FAIL midrst_bit3: txd=%b expected %b", txd, exp[4]);
      end
      rst_n = 1'b0;
      @(posedge ipclk); #1;
      check_idle("midrst_edge");
      rst_n = 1'b1;
      @(posedge ipclk); #1;
      check_idle("midrst_after");
      d = 8'($urandom);
      present(d, 3);
      expect_frame(d, 3, 1'b0, 1'b0, 8'h00, 3, "midrst_clean");
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic       p;
      int         div;
      for (int n = 0; n < 6; n++) begin
         d   = 8'($urandom);
         div = int'($urandom_range(0, 3));
         p   = 1'($urandom_range(0, 1));
`ifdef UART_TX_PARITY_EN
         tx_if.parity_odd = p;
`endif
         present(d, div);
         expect_frame(d, div, p, 1'b0, 8'h00, div, $sformatf("rand%0d", n));
      end
`ifdef UART_TX_PARITY_EN
      tx_if.parity_odd = 1'b0;
`endif
   endtask

   initial begin
      tx_if.tx_valid = 1'b0;
      tx_if.tx_data  = 8'h00;
`ifdef UART_TX_PARITY_EN
      tx_if.parity_odd = 1'b0;
`endif
      test_reset();
      test_a5();
      test_parity();
      test_back_to_back();
      test_div_change();
      test_midframe_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
